// File: rtl/cr_stream_ctrl_pkg.sv
// Shared types for the correlated-random stream controller.
// Counter/share types, beat/state enums, tuple struct, helpers.
package cr_stream_ctrl_pkg;

  localparam int CR_CNT_W  = 16;
  localparam int GUARD_CYC = 64;

  typedef logic [255:0]        prng_t;
  typedef logic [CR_CNT_W-1:0] cr_cnt_t;

  typedef enum logic [1:0] {
    BEAT_A = 2'd0,
    BEAT_B = 2'd1,
    BEAT_C = 2'd2
  } cr_beat_t;

  typedef struct packed {
    logic [7:0] e;
    prng_t      c;
    prng_t      b;
    prng_t      a;
  } cr_tuple_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    RUN   = 3'd2,
    GAP   = 3'd3,
    DRAIN = 3'd4
  } crs_state_t;

  function automatic cr_cnt_t cnt_min(
    input cr_cnt_t x,
    input cr_cnt_t y
  );
    return (x < y) ? x : y;
  endfunction

endpackage

// File: rtl/cr_stream_ctrl_tuple_fifo.sv
// cr_tuple_fifo: sync first-word-fall-through FIFO of cr_tuple_t.
// Ports: clk_i, rst_n_i, push_i/wdata_i, pop_i/rdata_o, count_o, empty_o, full_o.
module cr_tuple_fifo
  import cr_stream_ctrl_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          push_i,
  input  cr_tuple_t     wdata_i,
  input  logic          pop_i,
  output cr_tuple_t     rdata_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  cr_tuple_t     mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/cr_stream_ctrl.sv
// cr_stream_ctrl: credits CRG count bursts, buffers {a,b,c,e} tuples and
// serialises them as 3 x 256-bit beats. Ports: req_*, crg_*, m_t*, done/err/ovf;
// stat_beats_o/stat_stall_o exist only when CR_STREAM_STATS_EN is defined.
module cr_stream_ctrl
  import cr_stream_ctrl_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int BURST = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  cr_cnt_t      req_start_i,
  input  cr_cnt_t      req_num_i,
  output logic         crg_run_o,
  output cr_cnt_t      crg_cnt_start_o,
  output cr_cnt_t      crg_cnt_end_o,
  input  prng_t        crg_a_i,
  input  prng_t        crg_b_i,
  input  prng_t        crg_c_i,
  input  logic [7:0]   crg_e_i,
  input  logic         crg_dvld_i,
  output logic [255:0] m_tdata_o,
  output logic [9:0]   m_tuser_o,
  output logic         m_tlast_o,
  output logic         m_tvalid_o,
  input  logic         m_tready_i,
  output logic         done_o,
  output logic         err_o,
`ifdef CR_STREAM_STATS_EN
  output logic [31:0]  stat_beats_o,
  output logic [31:0]  stat_stall_o,
`endif
  output logic         ovf_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int GW = $clog2(GUARD_CYC + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CR_CNT_W:0] CNT_LIM = {1'b1, {CR_CNT_W{1'b0}}};

  crs_state_t    state_q, state_d;
  cr_cnt_t       cur_q, cur_d;
  cr_cnt_t       rem_q, rem_d;
  cr_cnt_t       gap_q, gap_d;
  cr_cnt_t       blen_q, blen_d;
  cr_cnt_t       cs_q, cs_d;
  cr_cnt_t       ce_q, ce_d;
  cr_cnt_t       num_q, num_d;
  cr_cnt_t       tup_q, tup_d;
  logic [CW-1:0] infl_q, infl_d;
  cr_beat_t      beat_q, beat_d;
  logic [GW-1:0] guard_q;
  logic          ovf_q;

  cr_tuple_t     f_wdata;
  cr_tuple_t     f_head;
  logic [CW-1:0] f_cnt;
  logic          f_empty;
  logic          f_full;

  logic              dvld;
  logic              idle_rdy;
  logic              accept;
  logic              req_bad;
  logic              credit_ok;
  logic              drain_ok;
  logic              hs;
  logic              pop;
  logic [CR_CNT_W:0] req_sum;
  logic [CW:0]       used;
  logic [CW:0]       free;
  cr_cnt_t           burst_b;

  // Tuples still arriving from a run cut short by reset are ignored.
  assign dvld     = crg_dvld_i & (guard_q == '0);
  assign idle_rdy = (state_q == IDLE) & (guard_q == '0);
  assign accept   = req_valid_i & idle_rdy;
  // start+num-1 > max  <=>  start+num > 2^W
  assign req_sum  = {1'b0, req_start_i} + {1'b0, req_num_i};
  assign req_bad  = (req_start_i == '0) | (req_num_i == '0) |
                    (req_sum > CNT_LIM);
  assign burst_b  = cnt_min(rem_q, cr_cnt_t'(BURST));
  assign used     = {1'b0, f_cnt} + {1'b0, infl_q};
  assign free     = (used >= DEPTH_C) ? '0 : DEPTH_C - used;
  assign credit_ok = cr_cnt_t'(free) >= burst_b;
  assign drain_ok = (infl_q == '0) & f_empty;
  assign hs       = m_tvalid_o & m_tready_i;
  assign pop      = hs & (beat_q == BEAT_C);
  assign f_wdata  = '{e: crg_e_i, c: crg_c_i, b: crg_b_i, a: crg_a_i};

  cr_tuple_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (dvld),
    .wdata_i (f_wdata),
    .pop_i   (pop),
    .rdata_o (f_head),
    .count_o (f_cnt),
    .empty_o (f_empty),
    .full_o  (f_full)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && !req_bad) state_d = WAIT;
      WAIT:    if (credit_ok) state_d = RUN;
      RUN:     state_d = GAP;
      GAP:     if (gap_q == '0) state_d = (rem_q != '0) ? WAIT : DRAIN;
      DRAIN:   if (drain_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = idle_rdy;
    crg_run_o   = (state_q == RUN);
    err_o       = accept & req_bad;
    done_o      = (state_q == DRAIN) & drain_ok;
  end

  always_comb begin
    cur_d  = cur_q;
    rem_d  = rem_q;
    gap_d  = gap_q;
    blen_d = blen_q;
    cs_d   = cs_q;
    ce_d   = ce_q;
    num_d  = num_q;
    if (state_q == IDLE && accept && !req_bad) begin
      cur_d = req_start_i;
      rem_d = req_num_i;
      num_d = req_num_i;
    end
    // Burst bounds settle one cycle early so they are valid with the pulse.
    if (state_q == WAIT && credit_ok) begin
      cs_d   = cur_q;
      ce_d   = cur_q + burst_b - cr_cnt_t'(1);
      blen_d = burst_b;
    end
    if (state_q == RUN) begin
      cur_d = cur_q + blen_q;
      rem_d = rem_q - blen_q;
      gap_d = blen_q;
    end
    if (state_q == GAP && gap_q != '0) gap_d = gap_q - cr_cnt_t'(1);
  end

  always_comb begin
    infl_d = infl_q;
    if (state_q == RUN) infl_d = infl_d + CW'(blen_q);
    if (dvld && infl_q != '0) infl_d = infl_d - CW'(1);
  end

  always_comb begin
    beat_d = beat_q;
    if (hs) begin
      unique case (beat_q)
        BEAT_A:  beat_d = BEAT_B;
        BEAT_B:  beat_d = BEAT_C;
        default: beat_d = BEAT_A;
      endcase
    end
  end

  always_comb begin
    tup_d = tup_q;
    if (accept && !req_bad) tup_d = '0;
    else if (pop)           tup_d = tup_q + cr_cnt_t'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cur_q   <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      blen_q  <= '0;
      cs_q    <= '0;
      ce_q    <= '0;
      num_q   <= '0;
      tup_q   <= '0;
      infl_q  <= '0;
      beat_q  <= BEAT_A;
      guard_q <= GW'(GUARD_CYC);
      ovf_q   <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      rem_q  <= rem_d;
      gap_q  <= gap_d;
      blen_q <= blen_d;
      cs_q   <= cs_d;
      ce_q   <= ce_d;
      num_q  <= num_d;
      tup_q  <= tup_d;
      infl_q <= infl_d;
      beat_q <= beat_d;
      if (guard_q != '0) guard_q <= guard_q - GW'(1);
      if (dvld && f_full && !pop) ovf_q <= 1'b1;
    end
  end

  assign crg_cnt_start_o = cs_q;
  assign crg_cnt_end_o   = ce_q;
  assign ovf_o           = ovf_q;
  // The in-flight tuple stays at the FIFO head until its C beat is taken.
  assign m_tvalid_o      = ~f_empty;

  always_comb begin
    m_tdata_o = '0;
    m_tuser_o = '0;
    m_tlast_o = 1'b0;
    if (m_tvalid_o) begin
      unique case (beat_q)
        BEAT_A:  m_tdata_o = f_head.a;
        BEAT_B:  m_tdata_o = f_head.b;
        default: m_tdata_o = f_head.c;
      endcase
      m_tuser_o = {beat_q, f_head.e};
      m_tlast_o = (beat_q == BEAT_C) & (tup_q + cr_cnt_t'(1) == num_q);
    end
  end

`ifdef CR_STREAM_STATS_EN
  logic [31:0] sb_q;
  logic [31:0] ss_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sb_q <= '0;
      ss_q <= '0;
    end else begin
      if (hs)                       sb_q <= sb_q + 32'd1;
      if (m_tvalid_o && !m_tready_i) ss_q <= ss_q + 32'd1;
    end
  end

  assign stat_beats_o = sb_q;
  assign stat_stall_o = ss_q;
`endif

endmodule

// File: tb/tb_cr_stream_ctrl.sv
// Directed bench for cr_stream_ctrl: CRG model, stream monitor, request tests.
// Expected tuples derive from the counter value via pat()/e_of().
module tb_cr_stream_ctrl;
  import cr_stream_ctrl_pkg::*;

  localparam int DEPTH = 64;
  localparam int BURST = 16;

  logic         clk = 1'b0;
  logic         rst_n_i;
  logic         req_valid_i;
  logic         req_ready_o;
  cr_cnt_t      req_start_i;
  cr_cnt_t      req_num_i;
  logic         crg_run_o;
  cr_cnt_t      crg_cnt_start_o;
  cr_cnt_t      crg_cnt_end_o;
  prng_t        crg_a_i;
  prng_t        crg_b_i;
  prng_t        crg_c_i;
  logic [7:0]   crg_e_i;
  logic         crg_dvld_i;
  logic [255:0] m_tdata_o;
  logic [9:0]   m_tuser_o;
  logic         m_tlast_o;
  logic         m_tvalid_o;
  logic         m_tready_i;
  logic         done_o;
  logic         err_o;
  logic         ovf_o;
`ifdef CR_STREAM_STATS_EN
  logic [31:0]  stat_beats_o;
  logic [31:0]  stat_stall_o;
`endif

  always #5 clk = ~clk;

  cr_stream_ctrl #(
    .DEPTH (DEPTH),
    .BURST (BURST)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_start_i     (req_start_i),
    .req_num_i       (req_num_i),
    .crg_run_o       (crg_run_o),
    .crg_cnt_start_o (crg_cnt_start_o),
    .crg_cnt_end_o   (crg_cnt_end_o),
    .crg_a_i         (crg_a_i),
    .crg_b_i         (crg_b_i),
    .crg_c_i         (crg_c_i),
    .crg_e_i         (crg_e_i),
    .crg_dvld_i      (crg_dvld_i),
    .m_tdata_o       (m_tdata_o),
    .m_tuser_o       (m_tuser_o),
    .m_tlast_o       (m_tlast_o),
    .m_tvalid_o      (m_tvalid_o),
    .m_tready_i      (m_tready_i),
    .done_o          (done_o),
    .err_o           (err_o),
`ifdef CR_STREAM_STATS_EN
    .stat_beats_o    (stat_beats_o),
    .stat_stall_o    (stat_stall_o),
`endif
    .ovf_o           (ovf_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [319:0] got,
                     input logic [319:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic prng_t pat(input logic [3:0] t, input int n);
    return {8{t, 28'(n)}};
  endfunction

  function automatic logic [7:0] e_of(input int n);
    return 8'(n) ^ 8'h5A;
  endfunction

  function automatic logic [319:0] outs();
    return {req_ready_o, crg_run_o, crg_cnt_start_o, crg_cnt_end_o,
            m_tdata_o, m_tuser_o, m_tlast_o, m_tvalid_o,
            done_o, err_o, ovf_o};
  endfunction

  // Monitor-owned state
  int   cyc = 0;
  int   runs = 0;
  int   last_run_cyc = 0;
  int   last_b = 0;
  int   run_s[64];
  int   run_e[64];
  int   beats = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   stray = 0;
  int   inj_seen = 0;
  logic ovf_seen = 1'b0;
  int   exp_next = 0;
  int   exp_beat = 0;
  int   exp_idx = 0;
  int   exp_num = 0;
  logic prev_stall = 1'b0;
  logic [265:0] prev_sig = '0;
  int   crg_q[$];

  // Stimulus-owned state
  int   tr_mode = 1;
  bit   mon_en = 1'b0;
  int   inj_tok = 0;
  int   b_runs, b_beats, b_done, b_err, b_stray;

  always @(negedge clk) begin
    int    n;
    logic  hs_now;
    prng_t ed;
    cyc++;
    case (tr_mode)
      0:       m_tready_i = 1'b0;
      1:       m_tready_i = 1'b1;
      default: m_tready_i = cyc[0];
    endcase
    if (inj_tok != inj_seen) begin
      for (int i = 0; i < 10; i++) crg_q.push_back(9000 + i);
      inj_seen = inj_tok;
    end
    if (crg_q.size() > 0) begin
      n = crg_q.pop_front();
      crg_dvld_i = 1'b1;
      crg_a_i = pat(4'hA, n);
      crg_b_i = pat(4'hB, n);
      crg_c_i = pat(4'hC, n);
      crg_e_i = e_of(n);
    end else begin
      crg_dvld_i = 1'b0;
    end
    if (crg_run_o) begin
      if (runs > 0)
        chk("run_gap", (cyc - last_run_cyc) >= last_b + 1, 1'b1);
      if (runs < 64) begin
        run_s[runs] = int'(crg_cnt_start_o);
        run_e[runs] = int'(crg_cnt_end_o);
      end
      last_b = int'(crg_cnt_end_o) - int'(crg_cnt_start_o) + 1;
      last_run_cyc = cyc;
      for (int k = int'(crg_cnt_start_o); k <= int'(crg_cnt_end_o); k++)
        crg_q.push_back(k);
      runs++;
    end
    if (req_valid_i && req_ready_o) begin
      exp_next = int'(req_start_i);
      exp_num  = int'(req_num_i);
      exp_idx  = 0;
      exp_beat = 0;
    end
    if (done_o) done_cnt++;
    if (err_o)  err_cnt++;
    if (ovf_o)  ovf_seen = 1'b1;
    hs_now = m_tvalid_o & m_tready_i;
    if (mon_en && prev_stall)
      chk("stall_hold", {m_tuser_o, m_tdata_o}, prev_sig);
    if (!mon_en && m_tvalid_o) stray++;
    if (mon_en && hs_now) begin
      case (exp_beat)
        0:       ed = pat(4'hA, exp_next);
        1:       ed = pat(4'hB, exp_next);
        default: ed = pat(4'hC, exp_next);
      endcase
      chk("beat", {m_tlast_o, m_tuser_o, m_tdata_o},
          {(exp_beat == 2) && (exp_idx == exp_num - 1),
           2'(exp_beat), e_of(exp_next), ed});
      if (exp_beat == 2) begin
        exp_beat = 0;
        exp_next++;
        exp_idx++;
      end else begin
        exp_beat++;
      end
      beats++;
    end
    prev_stall = m_tvalid_o & ~m_tready_i;
    prev_sig   = {m_tuser_o, m_tdata_o};
  end

  task automatic do_req(input int s, input int n);
    int k;
    @(posedge clk); #1;
    k = 0;
    while (!req_ready_o && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("req_ready", req_ready_o, 1'b1);
    b_runs  = runs;
    b_beats = beats;
    b_done  = done_cnt;
    b_err   = err_cnt;
    mon_en  = 1'b1;
    req_valid_i = 1'b1;
    req_start_i = cr_cnt_t'(s);
    req_num_i   = cr_cnt_t'(n);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int k;
    k = 0;
    while (done_cnt == b_done && k < bound) begin
      @(posedge clk); #1;
      k++;
    end
    chk(tag, done_cnt - b_done, 1);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_once"}, done_cnt - b_done, 1);
  endtask

  initial begin
    int k;
    int r_at;
    rst_n_i     = 1'b0;
    req_valid_i = 1'b0;
    req_start_i = '0;
    req_num_i   = '0;
    #22;
    chk("rst_outs", outs(), '0);
    @(posedge clk); #1;
    rst_n_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("guard_ready", req_ready_o, 1'b0);

    // 1: single short burst
    do_req(1, 5);
    wait_done("t1_done", 2000);
    chk("t1_runs", runs - b_runs, 1);
    chk("t1_start", run_s[b_runs], 1);
    chk("t1_end", run_e[b_runs], 5);
    chk("t1_beats", beats - b_beats, 15);

    // 2: multi-burst with a short tail
    do_req(100, 40);
    wait_done("t2_done", 3000);
    chk("t2_runs", runs - b_runs, 3);
    chk("t2_end0", run_e[b_runs], 115);
    chk("t2_end1", run_e[b_runs + 1], 131);
    chk("t2_end2", run_e[b_runs + 2], 139);
    chk("t2_start2", run_s[b_runs + 2], 132);
    chk("t2_beats", beats - b_beats, 120);

    // 3: backpressure stops runs at DEPTH reserved
    tr_mode = 0;
    do_req(2000, 200);
    repeat (300) @(posedge clk);
    #1;
    chk("t3_runs_held", runs - b_runs, 4);
    chk("t3_ovf", ovf_o, 1'b0);
    chk("t3_valid", m_tvalid_o, 1'b1);
    tr_mode = 1;
    wait_done("t3_done", 5000);
    chk("t3_beats", beats - b_beats, 600);
    chk("t3_runs", runs - b_runs, 13);
    chk("t3_ovf_seen", ovf_seen, 1'b0);

    // 4: rejected requests
    do_req(0, 3);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_err_start0", err_cnt - b_err, 1);
    chk("t4_ready", req_ready_o, 1'b1);
    r_at = b_runs;
    do_req(5, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_err_num0", err_cnt - b_err, 1);
    do_req(65535, 2);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_err_wrap", err_cnt - b_err, 1);
    chk("t4_no_run", runs - r_at, 0);
    chk("t4_ready2", req_ready_o, 1'b1);

    // 5: toggling ready
    tr_mode = 2;
    do_req(500, 8);
    wait_done("t5_done", 2000);
    chk("t5_beats", beats - b_beats, 24);
    tr_mode = 1;

    // 7: request ending at the max counter value
    do_req(65534, 2);
    wait_done("t7_done", 2000);
    chk("t7_end", run_e[b_runs], 65535);
    chk("t7_beats", beats - b_beats, 6);

    // 6: reset mid-burst
    do_req(1000, 40);
    k = 0;
    while (runs - b_runs < 2 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t6_runs", (runs - b_runs) >= 2, 1'b1);
    repeat (3) @(posedge clk);
    #3;
    mon_en  = 1'b0;
    b_stray = stray;
    r_at    = runs;
    rst_n_i = 1'b0;
    #1;
    chk("t6_rst_async", outs(), '0);
    repeat (3) @(posedge clk);
    #1;
    rst_n_i = 1'b1;
    inj_tok++;
    repeat (40) @(posedge clk);
    #1;
    chk("t6_stray", stray - b_stray, 0);
    chk("t6_no_run", runs - r_at, 0);
    chk("t6_guard", req_ready_o, 1'b0);
    do_req(7, 2);
    wait_done("t6_done", 2000);
    chk("t6_beats", beats - b_beats, 6);
    chk("t6_ovf", ovf_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
